// File: rtl/cam_frame_writer.sv
// OV7670-style camera bus to QVGA frame buffer writer with snapshot handshake.
// Optional macro FW_DECIMATE_EN: VGA source, keep even-x/even-y pixels only.
module cam_frame_writer #(
  parameter int H_PIX   = 320,
  parameter int V_LINES = 240,
  parameter int ADDR_W  = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cam_pclk,
  input  logic              cam_href,
  input  logic              cam_vsync,
  input  logic [7:0]        cam_data,
  input  logic              cap_val,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [15:0]       wData,
  output logic              cap_we,
  output logic              cap_busy,
  output logic              cap_done,
  output logic              frame_done,
  output logic              line_err
);

`ifdef FW_DECIMATE_EN
  localparam int SH = 1;
`else
  localparam int SH = 0;
`endif
  localparam int SRC_H = H_PIX << SH;
  localparam int SRC_V = V_LINES << SH;
  localparam int XW    = $clog2(SRC_H + 2);
  localparam int YW    = $clog2(SRC_V + 2);
  localparam logic [XW-1:0] X_LIM = XW'(SRC_H);
  localparam logic [YW-1:0] Y_LIM = YW'(SRC_V);

  typedef enum logic [1:0] {WAIT_VSYNC, BLANK, ACTIVE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        pclk_q, pclk_d;
  logic [1:0]        href_q, href_d, vsync_q, vsync_d;
  logic [1:0][7:0]   data_q, data_d;
  logic              href_p_q, href_p_d, vsync_p_q, vsync_p_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic              armed_q, armed_d, snap_q, snap_d;
  logic              we_q, we_d, cap_we_q, cap_we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              cap_busy_q, cap_busy_d, cap_done_q, cap_done_d;
  logic              frame_done_q, frame_done_d, line_err_q, line_err_d;

  logic       prise, href_s, vs_s, vs_rise, vs_fall, href_fall, keep;
  logic [7:0] byte_s;

  // href/vsync/data come from the same synced stage as pclk, so they stay aligned
  assign prise     = pclk_q[1] & ~pclk_q[2];
  assign href_s    = href_q[1];
  assign vs_s      = vsync_q[1];
  assign byte_s    = data_q[1];
  assign vs_rise   = vs_s & ~vsync_p_q;
  assign vs_fall   = ~vs_s & vsync_p_q;
  assign href_fall = ~href_s & href_p_q;

`ifdef FW_DECIMATE_EN
  assign keep = ~x_q[0] & ~y_q[0];
`else
  assign keep = 1'b1;
`endif

  always_comb begin
    pclk_d       = {pclk_q[1:0], cam_pclk};
    href_d       = {href_q[0], cam_href};
    vsync_d      = {vsync_q[0], cam_vsync};
    data_d       = {data_q[0], cam_data};
    state_d      = state_q;
    href_p_d     = href_p_q;
    vsync_p_d    = vsync_p_q;
    x_d          = x_q;
    y_d          = y_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    armed_d      = armed_q;
    snap_d       = snap_q;
    we_d         = 1'b0;
    cap_we_d     = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    cap_done_d   = 1'b0;
    frame_done_d = 1'b0;
    line_err_d   = line_err_q;

    // href/vsync edges are judged between successive pclk rises
    if (prise) begin
      href_p_d  = href_s;
      vsync_p_d = vs_s;
    end

    case (state_q)
      WAIT_VSYNC: if (prise && vs_rise) state_d = BLANK;
      BLANK: begin
        x_d     = '0;
        y_d     = '0;
        phase_d = 1'b0;
        if (prise && vs_fall) begin
          state_d = ACTIVE;
          snap_d  = armed_q;
          armed_d = 1'b0;
        end
      end
      ACTIVE: if (prise) begin
        // line closes before the frame when both happen on one rise
        if (href_fall) begin
          if (x_q != '0) y_d = (y_q == '1) ? y_q : y_q + 1'b1;
          if (x_q != X_LIM) line_err_d = 1'b1;
          x_d     = '0;
          phase_d = 1'b0;
        end
        if (vs_rise) begin
          frame_done_d = 1'b1;
          cap_done_d   = snap_q;
          snap_d       = 1'b0;
          phase_d      = 1'b0;
          state_d      = BLANK;
        end else if (href_s) begin
          if (!phase_q) begin
            hi_d    = byte_s;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            wdata_d = {hi_q, byte_s};
            x_d     = (x_q == '1) ? x_q : x_q + 1'b1;
            if (x_q < X_LIM && y_q < Y_LIM && keep) begin
              we_d     = 1'b1;
              cap_we_d = snap_q;
              waddr_d  = ADDR_W'(y_q >> SH) * ADDR_W'(H_PIX) + ADDR_W'(x_q >> SH);
            end
          end
        end
      end
      default: state_d = WAIT_VSYNC;
    endcase

    if (cap_val && !cap_busy_q) armed_d = 1'b1;
    // busy stays up through the cap_done cycle and drops one cycle after
    cap_busy_d = armed_d | snap_d | cap_done_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= WAIT_VSYNC;
      pclk_q       <= '0;
      href_q       <= '0;
      vsync_q      <= '0;
      data_q       <= '0;
      href_p_q     <= 1'b0;
      vsync_p_q    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      armed_q      <= 1'b0;
      snap_q       <= 1'b0;
      we_q         <= 1'b0;
      cap_we_q     <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      cap_busy_q   <= 1'b0;
      cap_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pclk_q       <= pclk_d;
      href_q       <= href_d;
      vsync_q      <= vsync_d;
      data_q       <= data_d;
      href_p_q     <= href_p_d;
      vsync_p_q    <= vsync_p_d;
      x_q          <= x_d;
      y_q          <= y_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      armed_q      <= armed_d;
      snap_q       <= snap_d;
      we_q         <= we_d;
      cap_we_q     <= cap_we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      cap_busy_q   <= cap_busy_d;
      cap_done_q   <= cap_done_d;
      frame_done_q <= frame_done_d;
      line_err_q   <= line_err_d;
    end
  end

  assign we         = we_q;
  assign wAddr      = waddr_q;
  assign wData      = wdata_q;
  assign cap_we     = cap_we_q;
  assign cap_busy   = cap_busy_q;
  assign cap_done   = cap_done_q;
  assign frame_done = frame_done_q;
  assign line_err   = line_err_q;

endmodule

// File: doc/cam_frame_writer.md
Name: cam_frame_writer

Overview:
Camera-side writer for the QVGA frame buffer. It samples an OV7670-style parallel camera bus (pclk, href, vsync, 8-bit data) in the system clock domain. It pairs bytes into RGB565 pixels and issues one-cycle write strobes with linear addresses y*320+x into the same 17-bit address space the VGA read path uses. It also provides a snapshot handshake: a cap_val pulse arms capture of the next complete frame, which is flagged on a separate strobe and ends with a done pulse.

Parameters:
H_PIX, 320, pixels written per line
V_LINES, 240, lines written per frame
ADDR_W, 17, write address width; must hold H_PIX*V_LINES-1

Ports:
clk  input  1  system clock; must be at least 4x cam_pclk
reset_n  input  1  asynchronous, active-low reset
cam_pclk  input  1  camera pixel clock, asynchronous to clk
cam_href  input  1  line valid, active high
cam_vsync  input  1  frame sync, active high during vertical blanking
cam_data  input  8  camera byte bus
cap_val  input  1  one-cycle snapshot request
we  output  1  frame buffer write strobe, one clk wide
wAddr  output  ADDR_W  write address
wData  output  16  RGB565 pixel; first byte = [15:8], second byte = [7:0]
cap_we  output  1  equals we during a snapshot frame, else 0
cap_busy  output  1  snapshot armed or in progress
cap_done  output  1  one-cycle pulse at the end of a snapshot frame
frame_done  output  1  one-cycle pulse at the end of every frame
line_err  output  1  sticky flag: some line's pixel count differed from H_PIX

Behaviour:
- Reset (reset_n=0, async): all outputs 0, all counters 0, byte phase 0, FSM = WAIT_VSYNC.
- Input sampling: cam_pclk, cam_href, cam_vsync and cam_data each pass through a 2-FF synchronizer plus one history stage. A pclk rise (prise) = synced high AND history low. href, vsync and data are all taken from the same delayed stage as pclk, so they stay aligned.
- FSM states:
  - WAIT_VSYNC: wait for a vsync rise, then go to BLANK.
  - BLANK: hold x=0, y=0, byte phase=0. On vsync fall, go to ACTIVE.
  - ACTIVE: on each prise with href=1:
    - phase 0: latch the byte into hi, set phase=1.
    - phase 1: drive wData={hi,byte}, set phase=0, and if x<H_PIX and y<V_LINES, pulse we for one clk in the following cycle with wAddr=y*H_PIX+x; then increment x.
  - ACTIVE, href fall: if x≠0, then y++; if x≠H_PIX, set line_err. Then x=0, phase=0.
  - ACTIVE, vsync rise: pulse frame_done, go to BLANK.
- Address arithmetic: wAddr is computed as y*H_PIX+x, truncated to ADDR_W. Writes with x≥H_PIX or y≥V_LINES are dropped (no we); counters saturate and do not wrap.
- Latency: we asserts 1 clk after the prise that captured the second byte. wAddr/wData are stable while we=1.
- Snapshot handshake:
  - A cap_val pulse sets cap_busy=1 (armed) the next cycle.
  - At the next BLANK→ACTIVE transition, the snapshot becomes active; cap_we mirrors we for that whole frame.
  - At that frame's vsync rise, cap_done and frame_done pulse in the same cycle, and cap_busy clears one cycle later.
  - cap_val while cap_busy=1 is ignored.
  - cap_val during an ACTIVE frame arms the snapshot for the next frame, not the current one.
- Simultaneous events:
  - vsync rise and href fall on the same prise: the line closes first, then the frame closes.
  - A vsync rise while phase=1: the pending byte is discarded.
- Reset mid-frame: everything clears. The block resynchronizes at the next vsync rise; a partial frame never produces frame_done.
- line_err clears only on reset.

Optional Feature:
FW_DECIMATE_EN
- Defined: the camera is assumed to output VGA (640x480). Only pixels with even source x and even source y are written, at address (ys/2)*H_PIX+(xs/2). The line_err check compares against 2*H_PIX source pixels. Odd source lines produce no writes.
- Undefined: every pixel is written 1:1, and the camera must be configured for QVGA.

Test Plan:
- QVGA frame (vsync pulse, 240 lines of href, each 640 bytes of incrementing pattern) -> 76800 we pulses; first wAddr=0, last wAddr=76799; pixel 5 wData={byte10,byte11}; one frame_done; line_err=0.
- Line of 642 bytes (321 pixels) -> the 321st pixel is not written; next line starts at wAddr=320; line_err=1 and stays 1.
- cap_val mid-frame -> cap_busy=1 immediately; cap_we=0 for the rest of that frame; next frame has 76800 cap_we pulses; cap_done coincides with frame_done; cap_busy=0 one cycle later.
- reset_n low at line 100, then released -> outputs 0; no we before the next vsync rise; the following frame starts at wAddr=0.
- vsync rises with phase=1 (odd byte count) -> no write for the orphan byte; the next frame's first pixel pairs correctly at wAddr=0.
- FW_DECIMATE_EN defined, 640x480 source with a pixel value encoding (xs,ys) -> 76800 writes; wAddr=321 carries the pixel from source (2,2).
